// File: rtl/param_mux_rr_if.sv
// Handshake bundle between N producer channels, the mux and its single consumer.
// Optional out_parity signal is present only when PARAM_MUX_PARITY_EN is defined.
interface param_mux_rr_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
`ifdef PARAM_MUX_PARITY_EN
  logic                    out_parity;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_parity
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_parity
  );
`else
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
`endif
endinterface

// File: rtl/param_mux_rr.sv
// Registered N-channel valid/ready mux with manual select or round-robin arbitration.
// Define PARAM_MUX_PARITY_EN to add a registered even-parity bit (out_parity).
module param_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input logic          clk,
  input logic          rst_n,
  param_mux_rr_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  cand;
  logic              grant_valid;
  logic              can_load;
  logic              fire;
  logic [NUM_CH-1:0] ready_vec;
  logic [WIDTH-1:0]  grant_data;
  logic [WIDTH-1:0]  data_q;
  logic [SEL_W-1:0]  ch_q;
  logic              valid_q;

  // First valid channel at or after rr_ptr wins in auto mode; sel wins in manual mode.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (bus.mode) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
        if (!grant_valid && bus.in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end else if (int'(bus.sel) < NUM_CH) begin
      grant_valid = bus.in_valid[bus.sel];
      grant_idx   = bus.sel;
    end
  end

  assign can_load = !valid_q || bus.out_ready;

  always_comb begin
    ready_vec = '0;
    if (rst_n && can_load && grant_valid)
      ready_vec[grant_idx] = 1'b1;
  end

  assign bus.in_ready = ready_vec;
  assign fire         = |(bus.in_valid & ready_vec);
  assign grant_data   = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];

  // A load on the same edge as a drain simply overwrites, keeping out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      rr_ptr  <= '0;
    end else if (fire) begin
      valid_q <= 1'b1;
      data_q  <= grant_data;
      ch_q    <= grant_idx;
      if (bus.mode)
        rr_ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

`ifdef PARAM_MUX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      parity_q <= 1'b0;
    else if (fire)
      parity_q <= ^grant_data;
  end

  assign bus.out_parity = parity_q;
`endif
endmodule

// File: tb/tb_param_mux_rr.sv
// Directed bench for param_mux_rr: a per-cycle reference model plus hand-computed checkpoints.
module tb_param_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  // Reference model state: contents of the output register and the fairness pointer.
  logic [W-1:0] m_data  = '0;
  int           m_ch    = 0;
  logic         m_valid = 1'b0;
  logic         m_par   = 1'b0;
  int           m_ptr   = 0;

  param_mux_rr_if #(.NUM_CH(N), .WIDTH(W)) bus ();

  param_mux_rr #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] make_data(input logic [7:0] d0, input logic [7:0] d1,
                                            input logic [7:0] d2, input logic [7:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Which channel should be granted right now, or -1: nearest valid channel clockwise
  // from the pointer in auto mode, the selected channel if valid in manual mode.
  function automatic int model_grant();
    int best;
    int bestd;
    int d;
    if (!rst_n) return -1;
    if (m_valid && !bus.out_ready) return -1;
    if (bus.mode) begin
      best  = -1;
      bestd = N;
      for (int k = 0; k < N; k++) begin
        d = (k - m_ptr + N) % N;
        if (bus.in_valid[k] && d < bestd) begin
          best  = k;
          bestd = d;
        end
      end
      return best;
    end
    if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    logic [W-1:0] w;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_par   = 1'b0;
      m_ptr   = 0;
    end else begin
      g = model_grant();
      if (g >= 0) begin
        w       = bus.in_data[g*W +: W];
        m_data  = w;
        m_ch    = g;
        m_valid = 1'b1;
        m_par   = ^w;
        if (bus.mode) m_ptr = (g + 1) % N;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic r, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.mode      = m;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = r;
    bus.in_data   = d;
  endtask

  always @(negedge clk) begin
    int g;
    logic [3:0] exp_ready;
    if (cmp_en) begin
      g         = model_grant();
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      checkOutput("cyc_in_ready", 32'(bus.in_ready), 32'(exp_ready));
      checkOutput("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
      checkOutput("cyc_out_data", 32'(bus.out_data), 32'(m_data));
      checkOutput("cyc_out_ch", 32'(bus.out_ch), 32'(m_ch));
`ifdef PARAM_MUX_PARITY_EN
      checkOutput("cyc_out_parity", 32'(bus.out_parity), 32'(m_par));
`endif
    end
  end

  initial begin
    logic [31:0] rr_data;
    logic [7:0]  exp_rr;
    rr_data       = make_data(8'h10, 8'h11, 8'h12, 8'h13);
    rst_n         = 1'b0;
    bus.mode      = 1'b1;
    bus.sel       = 2'd0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    bus.in_data   = rr_data;

    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("reset_out_ch", 32'(bus.out_ch), 32'h0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_rr_grant", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_rr = 8'h10 + 8'(i % 4);
      checkOutput("rr_seq_valid", 32'(bus.out_valid), 32'h1);
      checkOutput("rr_seq_ch", 32'(bus.out_ch), 32'(i % 4));
      checkOutput("rr_seq_data", 32'(bus.out_data), 32'(exp_rr));
    end

    applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1, rr_data);
    applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1, rr_data);
    @(negedge clk);
    checkOutput("wrap_pre_ch", 32'(bus.out_ch), 32'h2);
    checkOutput("wrap_ready_ch3", 32'(bus.in_ready), 32'h8);
    @(negedge clk);
    checkOutput("wrap_ch3", 32'(bus.out_ch), 32'h3);
    @(negedge clk);
    checkOutput("wrap_ch0", 32'(bus.out_ch), 32'h0);
    @(negedge clk);
    checkOutput("wrap_ch3_again", 32'(bus.out_ch), 32'h3);
    checkOutput("wrap_data", 32'(bus.out_data), 32'h13);

    applyStimulus(1'b0, 2'd2, 4'b0101, 1'b1, make_data(8'h10, 8'h11, 8'hA5, 8'h13));
    @(negedge clk);
    checkOutput("man_ready", 32'(bus.in_ready), 32'h4);
    @(negedge clk);
    checkOutput("man_data", 32'(bus.out_data), 32'hA5);
    checkOutput("man_ch", 32'(bus.out_ch), 32'h2);
    applyStimulus(1'b0, 2'd3, 4'b0111, 1'b1, make_data(8'h10, 8'h11, 8'hA5, 8'h13));
    @(negedge clk);
    checkOutput("man_sel3_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    checkOutput("man_sel3_drained", 32'(bus.out_valid), 32'h0);

    applyStimulus(1'b1, 2'd0, 4'b0010, 1'b0, make_data(8'h00, 8'h55, 8'h00, 8'h00));
    @(negedge clk);
    checkOutput("bp_first_ready", 32'(bus.in_ready), 32'h2);
    applyStimulus(1'b1, 2'd0, 4'b0010, 1'b0, make_data(8'h00, 8'h66, 8'h00, 8'h00));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_data", 32'(bus.out_data), 32'h55);
      checkOutput("bp_hold_ready", 32'(bus.in_ready), 32'h0);
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    end
    applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1, make_data(8'h00, 8'h66, 8'h00, 8'h00));
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'h2);
    checkOutput("bp_release_data", 32'(bus.out_data), 32'h55);
    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, make_data(8'h00, 8'h66, 8'h00, 8'h00));
    @(negedge clk);
    checkOutput("bp_swap_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("bp_swap_data", 32'(bus.out_data), 32'h66);
    checkOutput("bp_swap_ch", 32'(bus.out_ch), 32'h1);
    @(negedge clk);
    checkOutput("bp_drain_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("bp_drain_hold", 32'(bus.out_data), 32'h66);

    applyStimulus(1'b1, 2'd0, 4'b0001, 1'b1, make_data(8'h07, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    checkOutput("par_ready", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b1, 2'd0, 4'b0001, 1'b1, make_data(8'h03, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    checkOutput("par_data07", 32'(bus.out_data), 32'h07);
`ifdef PARAM_MUX_PARITY_EN
    checkOutput("par_bit07", 32'(bus.out_parity), 32'h1);
`endif
    applyStimulus(1'b1, 2'd0, 4'b0001, 1'b1, make_data(8'h03, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    checkOutput("par_data03", 32'(bus.out_data), 32'h03);
`ifdef PARAM_MUX_PARITY_EN
    checkOutput("par_bit03", 32'(bus.out_parity), 32'h0);
`endif

    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("midrst_pending", 32'(bus.out_valid), 32'h1);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_data  = rr_data;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst_data", 32'(bus.out_data), 32'h0);
    checkOutput("midrst_ch", 32'(bus.out_ch), 32'h0);
    checkOutput("midrst_ptr0", 32'(bus.in_ready), 32'h1);
`ifdef PARAM_MUX_PARITY_EN
    checkOutput("midrst_parity", 32'(bus.out_parity), 32'h0);
`endif
    @(negedge clk);
    checkOutput("post_rst_ch0", 32'(bus.out_ch), 32'h0);
    checkOutput("post_rst_data", 32'(bus.out_data), 32'h10);

    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1, rr_data);
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_mux_rr.md
Name: param_mux_rr

Overview:
Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshakes on every input channel and on the output. It selects one input per cycle, either by an explicit select input (manual mode) or by a round-robin arbiter (auto mode). The selected word is registered with its channel index. It sits between multiple producer channels and a single consumer, and succeeds the earlier fixed-width combinational mux.

Parameters:
NUM_CH, 4, number of input channels (2..16)
WIDTH, 8, data width per channel in bits
SEL_W, $clog2(NUM_CH), width of sel/out_ch; derived, never overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
mode  input  1  0 = manual select, 1 = round-robin
sel  input  SEL_W  channel to grant in manual mode
in_data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready, one-hot or zero
out_data  output  WIDTH  registered selected data
out_ch  output  SEL_W  registered index of the granted channel
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is forced to all-zero while rst_n=0.
- can_load = !out_valid | out_ready. No grant is issued unless can_load=1.
- Manual mode grant:
  - Channel sel is granted if in_valid[sel]=1.
  - If sel >= NUM_CH, nothing is granted.
  - Valid inputs on other channels are ignored and stall.
- Round-robin grant: search from rr_ptr upward, modulo NUM_CH; the first channel with in_valid=1 is granted.
- in_ready is combinational: in_ready[g]=1 only for the granted channel g, and only when can_load=1. All other bits are 0.
- Transfer: at posedge with in_valid[g]&in_ready[g], out_data<=data[g], out_ch<=g, out_valid<=1.
- Pointer update:
  - In round-robin mode only, rr_ptr<=(g+1) mod NUM_CH, wrapping NUM_CH-1 to 0.
  - In manual mode rr_ptr holds.
- Drain: if out_valid&out_ready and there is no new grant, out_valid<=0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and out_valid stays 1. This gives full throughput, one word per cycle.
- Stall: if out_valid=1 and out_ready=0, the output register holds and all in_ready bits are 0.
- Latency: one cycle from the input handshake to out_valid.
- Mode or sel changes take effect on the next grant decision. A word already in the output register is unaffected.
- Reset mid-transfer: a pending output word is discarded, out_valid=0 on the next cycle, and the pointer returns to 0.
- No combinational path from in_data to out_data.

Optional Feature:
PARAM_MUX_PARITY_EN
- Defined:
  - Adds output port out_parity (1 bit), registered alongside out_data.
  - out_parity = ^data[g], i.e. even parity, so the XOR of out_data and out_parity is 0.
  - out_parity resets to 0 and holds with out_data.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000; after release, first RR grant is ch0.
2. Manual mode, sel=2, in_valid=4'b0101, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2; ch0 gets no grant. sel=5 with NUM_CH=6 overridden to 4 is N/A; with NUM_CH=4 and sel=3 with in_valid[3]=0 -> no grant.
3. Round-robin, in_valid=4'b1111 held, out_ready=1, data[k]=8'h10+k -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data 10,11,12,13,10; out_valid stays 1.
4. Round-robin fairness with wrap: rr_ptr=3, in_valid=4'b1001 -> grant ch3, then ch0, then ch3.
5. Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data stable, in_ready=0; on out_ready=1 with a pending input -> same-edge drain and load, out_valid stays 1, no word lost or duplicated.
6. With PARAM_MUX_PARITY_EN: data 8'h07 -> out_parity=1; data 8'h03 -> out_parity=0; reset mid-stream -> out_valid=0 and out_parity=0 next cycle.
